// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 encodings,
// FSM state type and the store byte-enable helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

  // Lane mask for a store of the size encoded in funct3[1:0].
  function automatic logic [3:0] lsu_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a bus read word and
// sign- or zero-extends it to 32 bits.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    unique case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_funct3)
      LB:      o_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_data = {{16{w_half[15]}}, w_half};
      LBU:     o_data = {24'h000000, w_byte};
      LHU:     o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus transaction per MEM access, with the
// pipeline stalled from acceptance until the response has been consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memaccessm,
  input  logic              memwritem,
  input  logic [2:0]        funct3m,
  input  logic [ADDR_W-1:0] addrm,
  input  logic [31:0]       writedatam,
  output logic [31:0]       readdatam,
  output logic              stallm,
  output logic              faultm,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e r_state, w_state_next;

  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_funct3;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_readdata;

  logic        w_legal;
  logic        w_accept;
  logic        w_capture;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;

  // Unsigned-size stores do not exist, so funct3[2] is only legal for loads.
  always_comb begin
    w_legal = 1'b0;
    case (funct3m)
      LB, LBU: w_legal = !(memwritem && funct3m[2]);
      LH, LHU: w_legal = !addrm[0] && !(memwritem && funct3m[2]);
      LW:      w_legal = (addrm[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_be = memwritem ? lsu_be(funct3m, addrm[1:0]) : 4'b1111;
    case (funct3m[1:0])
      2'b00:   w_wdata = {4{writedatam[7:0]}};
      2'b01:   w_wdata = {2{writedatam[15:0]}};
      default: w_wdata = writedatam;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    stallm       = 1'b0;
    faultm       = 1'b0;
    bus_req      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (memaccessm) begin
          if (w_legal) begin
            w_accept     = 1'b1;
            stallm       = 1'b1;
            w_state_next = StReq;
          end else begin
            faultm = 1'b1;
          end
        end
      end
      StReq: begin
        stallm  = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) w_state_next = StWait;
      end
      StWait: begin
        stallm = 1'b1;
        if (bus_rvalid) begin
          w_capture    = !r_we;
          w_state_next = StDone;
        end
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  load_align u_load_align (
    .i_rdata   (bus_rdata),
    .i_addr_lo (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_data    (w_load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_funct3   <= 3'b000;
      r_we       <= 1'b0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'h0;
      r_readdata <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_addr   <= addrm;
        r_funct3 <= funct3m;
        r_we     <= memwritem;
        r_be     <= w_be;
        r_wdata  <= w_wdata;
      end
      if (w_capture) r_readdata <= w_load_ext;
    end
  end

  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  // A faulting access reports zero without disturbing the held load result.
  assign readdatam = faultm ? 32'h0 : r_readdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a size/offset arithmetic model.
module tb_load_store_unit;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          memaccessm, memwritem;
  logic [2:0]    funct3m;
  logic [AW-1:0] addrm;
  logic [31:0]   writedatam, readdatam;
  logic          stallm, faultm, bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_be;
  logic [31:0]   bus_wdata;
  logic          bus_gnt, bus_rvalid;
  logic [31:0]   bus_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] model_rd = 32'h0;

  typedef struct {
    int            stall;
    int            fault_cycles;
    int            req_cycles;
    int            first_req;
    int            last_req;
    bit            stable;
    bit            timeout;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rd;
  } obs_t;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .memaccessm (memaccessm),
    .memwritem  (memwritem),
    .funct3m    (funct3m),
    .addrm      (addrm),
    .writedatam (writedatam),
    .readdatam  (readdatam),
    .stallm     (stallm),
    .faultm     (faultm),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: access size in bytes and architectural rules.
  function automatic int ref_size(input logic [2:0] f3);
    return 1 << int'(f3[1:0]);
  endfunction

  function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (we && f3 >= 3'd4) return 1'b0;
    return (a % ref_size(f3)) == 0;
  endfunction

  function automatic logic [3:0] ref_be(input bit we, input logic [2:0] f3,
                                        input logic [31:0] a);
    int m;
    if (!we) return 4'hF;
    m = ((1 << ref_size(f3)) - 1) << int'(a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = ref_size(f3);
    if (sz == 1) return {24'h0, wd[7:0]} * 32'h01010101;
    if (sz == 2) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    longint v;
    longint span;
    int sz;
    sz = ref_size(f3);
    if (sz == 4) return rdata;
    span = longint'(1) << (8 * sz);
    v = (longint'(rdata) >> (8 * int'(a % 4))) % span;
    if (f3 < 3'd4 && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // Drives one MEM access and services the bus; reports what it saw.
  task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdata, input int gdly,
                            input int rdly, input bit noise, output obs_t o);
    int gnt_at;
    bit done;
    o.stall = 0; o.fault_cycles = 0; o.req_cycles = 0; o.first_req = -1; o.last_req = -1;
    o.stable = 1'b1; o.timeout = 1'b0; o.we = 1'b0; o.addr = '0; o.be = 4'h0;
    o.wdata = 32'h0; o.rd = 32'h0;
    @(posedge clk); #1;
    memaccessm = 1'b1; memwritem = we; funct3m = f3; addrm = a; writedatam = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    gnt_at = -1;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (stallm) o.stall++;
      if (faultm) o.fault_cycles++;
      if (bus_req) begin
        if (o.req_cycles == 0) begin
          o.we = bus_we; o.addr = bus_addr; o.be = bus_be; o.wdata = bus_wdata;
          o.first_req = cyc;
        end else if ({bus_we, bus_addr, bus_be, bus_wdata} !== {o.we, o.addr, o.be, o.wdata}) begin
          o.stable = 1'b0;
        end
        if (o.req_cycles == gdly) begin
          bus_gnt = 1'b1;
          gnt_at = c;
        end else if (noise) begin
          bus_rvalid = 1'($urandom_range(0, 1));
        end
        o.last_req = cyc;
        o.req_cycles++;
      end else if (gnt_at >= 0 && c == gnt_at + rdly) begin
        bus_rvalid = 1'b1;
        bus_rdata = rdata;
      end else if (noise && gnt_at >= 0 && c > gnt_at && c < gnt_at + rdly) begin
        bus_gnt = 1'($urandom_range(0, 1));
      end
      if (!stallm) begin
        done = 1'b1;
        o.rd = readdatam;
      end else begin
        @(posedge clk); #1;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      end
    end
    if (!done) o.timeout = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      memaccessm = 1'b0; memwritem = 1'($urandom_range(0, 1)); addrm = $urandom;
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; memaccessm = 1'b0; memwritem = 1'b0; funct3m = 3'd0; addrm = '0;
    writedatam = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stallm, faultm, bus_req, bus_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got stall/fault/req/we=%b exp 0000",
               {stallm, faultm, bus_req, bus_we});
    end
    checks++;
    if ({bus_addr, bus_be, bus_wdata, readdatam} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h be=%b wdata=%h rd=%h exp all zero",
               bus_addr, bus_be, bus_wdata, readdatam);
    end
  endtask

  task automatic test_lb();
    obs_t o;
    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 1'b0, o);
    model_rd = 32'hFFFF_FF80;
    checks++;
    if (o.timeout) begin errors++; $display("FAIL lb_timeout got timeout exp completion"); end
    checks++;
    if (o.addr !== 32'h100) begin
      errors++; $display("FAIL lb_addr got %h exp 00000100", o.addr);
    end
    checks++;
    if (o.be !== 4'b1111) begin errors++; $display("FAIL lb_be got %b exp 1111", o.be); end
    checks++;
    if (o.rd !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_data got %h exp ffffff80", o.rd);
    end
    checks++;
    if (o.stall != 3) begin errors++; $display("FAIL lb_stall got %0d exp 3", o.stall); end
  endtask

  task automatic test_sh();
    obs_t o;
    run_access(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, $urandom, 0, 1, 1'b0, o);
    checks++;
    if (o.addr !== 32'h200) begin
      errors++; $display("FAIL sh_addr got %h exp 00000200", o.addr);
    end
    checks++;
    if (o.be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b exp 1100", o.be); end
    checks++;
    if (o.wdata !== 32'hABCD_ABCD) begin
      errors++; $display("FAIL sh_wdata got %h exp abcdabcd", o.wdata);
    end
    checks++;
    if (o.we !== 1'b1) begin errors++; $display("FAIL sh_we got %b exp 1", o.we); end
    checks++;
    if (o.rd !== model_rd) begin
      errors++; $display("FAIL sh_rd_held got %h exp %h", o.rd, model_rd);
    end
  endtask

  task automatic test_lhu_delayed();
    obs_t o;
    run_access(1'b0, 3'b101, 32'h10, $urandom, 32'h1234_8001, 2, 3, 1'b0, o);
    model_rd = 32'h0000_8001;
    checks++;
    if (o.rd !== 32'h0000_8001) begin
      errors++; $display("FAIL lhu_data got %h exp 00008001", o.rd);
    end
    checks++;
    if (o.stall != 7) begin errors++; $display("FAIL lhu_stall got %0d exp 7", o.stall); end
    checks++;
    if (o.stable !== 1'b1 || o.req_cycles != 3) begin
      errors++;
      $display("FAIL lhu_req_stable got stable=%b req_cycles=%0d exp stable=1 req_cycles=3",
               o.stable, o.req_cycles);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) run_access(1'b0, 3'b010, 32'h06, 32'h0, $urandom, 0, 1, 1'b0, o);
      else        run_access(1'b1, 3'b110, 32'h20, $urandom, $urandom, 0, 1, 1'b0, o);
      checks++;
      if (o.fault_cycles != 1 || o.stall != 0) begin
        errors++;
        $display("FAIL fault%0d_resp got fault_cycles=%0d stall=%0d exp 1 and 0",
                 k, o.fault_cycles, o.stall);
      end
      checks++;
      if (o.rd !== 32'h0) begin
        errors++; $display("FAIL fault%0d_rd got %h exp 00000000", k, o.rd);
      end
      idle(1);
      @(negedge clk);
      checks++;
      if (faultm !== 1'b0 || bus_req !== 1'b0 || o.first_req != -1) begin
        errors++;
        $display("FAIL fault%0d_pulse got fault=%b req=%b req_seen=%0d exp 0 0 -1",
                 k, faultm, bus_req, o.first_req);
      end
    end
  endtask

  task automatic test_reset_wait();
    obs_t o;
    logic [31:0] wd;
    @(posedge clk); #1;
    memaccessm = 1'b1; memwritem = 1'b0; funct3m = 3'b010; addrm = 32'h44;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin errors++; $display("FAIL rstw_req got %b exp 1", bus_req); end
    bus_gnt = 1'b1;
    @(posedge clk); #1 bus_gnt = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; memaccessm = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    model_rd = 32'h0;
    checks++;
    if ({stallm, faultm, bus_req, bus_we, bus_addr, bus_be, bus_wdata, readdatam} !== '0) begin
      errors++;
      $display("FAIL rstw_outputs got stall=%b req=%b we=%b addr=%h be=%b wd=%h rd=%h exp 0",
               stallm, bus_req, bus_we, bus_addr, bus_be, bus_wdata, readdatam);
    end
    @(posedge clk); #1 bus_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (stallm !== 1'b0 || bus_req !== 1'b0 || readdatam !== 32'h0) begin
      errors++;
      $display("FAIL rstw_stray got stall=%b req=%b rd=%h exp 0 0 0", stallm, bus_req, readdatam);
    end
    wd = $urandom;
    run_access(1'b1, 3'b010, 32'h40, wd, $urandom, 0, 1, 1'b0, o);
    checks++;
    if (o.stall != 3 || o.addr !== 32'h40 || o.be !== 4'hF || o.wdata !== wd || o.we !== 1'b1)
    begin
      errors++;
      $display("FAIL rstw_sw got stall=%0d addr=%h be=%b wd=%h we=%b exp 3 00000040 1111 %h 1",
               o.stall, o.addr, o.be, o.wdata, o.we, wd);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    idle(1);
    run_access(1'b1, 3'b010, 32'h00, $urandom, $urandom, 0, 1, 1'b0, o1);
    run_access(1'b0, 3'b010, 32'h00, $urandom, 32'hDEAD_BEEF, 0, 1, 1'b0, o2);
    model_rd = 32'hDEAD_BEEF;
    checks++;
    if (o2.first_req - o1.last_req != 4) begin
      errors++;
      $display("FAIL b2b_gap got %0d cycles between req pulses exp 4", o2.first_req - o1.last_req);
    end
    checks++;
    if (o2.rd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL b2b_lw got %h exp deadbeef", o2.rd);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit we, legal;
    logic [2:0] f3;
    logic [31:0] a, wd, rd;
    int g, r, exp_stall;
    for (int i = 0; i < 60; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      wd = $urandom; rd = $urandom;
      g = $urandom_range(0, 3); r = $urandom_range(1, 3);
      run_access(we, f3, a, wd, rd, g, r, 1'b1, o);
      legal = ref_legal(we, f3, a);
      exp_stall = legal ? 3 + g + (r - 1) : 0;
      checks++;
      if (o.stall != exp_stall || o.timeout) begin
        errors++;
        $display("FAIL rnd%0d_stall got %0d timeout=%b exp %0d", i, o.stall, o.timeout, exp_stall);
      end
      checks++;
      if (o.fault_cycles != (legal ? 0 : 1) || (o.first_req == -1) == legal) begin
        errors++;
        $display("FAIL rnd%0d_legal got fault_cycles=%0d req_seen=%0b exp legal=%0b",
                 i, o.fault_cycles, o.first_req != -1, legal);
      end
      if (legal) begin
        checks++;
        if (o.addr !== (a & 32'hFFFF_FFFC) || o.be !== ref_be(we, f3, a) || o.we !== we
            || !o.stable) begin
          errors++;
          $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b stable=%b exp %h %b %b 1", i,
                   o.addr, o.be, o.we, o.stable, a & 32'hFFFF_FFFC, ref_be(we, f3, a), we);
        end
        if (we) begin
          checks++;
          if (o.wdata !== ref_wdata(f3, wd)) begin
            errors++;
            $display("FAIL rnd%0d_wdata got %h exp %h", i, o.wdata, ref_wdata(f3, wd));
          end
        end else begin
          model_rd = ref_load(f3, a, rd);
        end
      end
      checks++;
      if (o.rd !== (legal ? model_rd : 32'h0)) begin
        errors++;
        $display("FAIL rnd%0d_rd got %h exp %h", i, o.rd, legal ? model_rd : 32'h0);
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    idle(1);
    test_sh();
    idle(2);
    test_lhu_delayed();
    idle(1);
    test_misaligned();
    test_reset_wait();
    test_back_to_back();
    idle(1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
